uart_tx_os: RTL and testbench

- Serial transmitter that is the transmit-side counterpart of the oversampling receive path.
- Accepts parallel words over a valid/ready handshake and drives a UART-style line, LSB first.
- Each bit is held for exactly OSR clk cycles, matching the receiver's 20x oversampling window.
- Used to send configuration/command frames to the GPS module.
- Provides a one-entry holding register so consecutive frames go out back-to-back with no idle gap.

---
 rtl/gps_uart_pkg.sv | 28 ++
 rtl/os_tick_gen.sv | 31 +++
 rtl/uart_tx_os.sv | 113 +++++++++++
 tb/tb_uart_tx_os.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_uart_pkg.sv
// Shared definitions for the GPS UART transmit and receive paths.
package gps_uart_pkg;

    localparam int DEFAULT_OSR = 20;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // Only the low nbits of data take part; odd mode inverts the XOR so the frame has an odd count of ones.
    function automatic logic parity_bit(input logic [8:0] data, input int nbits, input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/os_tick_gen.sv
// Oversampling slot counter: counts 0..OSR-1 while enabled and flags the last cycle of each slot.
module os_tick_gen
    import gps_uart_pkg::*;
#(
    parameter int OSR = DEFAULT_OSR
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic slot_end
);

    localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CW-1:0] LAST = CW'(OSR - 1);

    logic [CW-1:0] os_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            os_cnt <= '0;
        end else if (clr) begin
            os_cnt <= '0;
        end else if (en) begin
            os_cnt <= (os_cnt == LAST) ? '0 : os_cnt + 1'b1;
        end
    end

    assign slot_end = en && !clr && (os_cnt == LAST);

endmodule

// File: rtl/uart_tx_os.sv
// UART transmitter with OSR clocks per bit and a one-word holding register for gapless back-to-back frames.
module uart_tx_os
    import gps_uart_pkg::*;
#(
    parameter int OSR       = DEFAULT_OSR,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    tx_state_t state, state_nxt;
    logic [DATA_BITS-1:0] shift_reg, hold_reg, word_in;
    logic [IW-1:0] bit_idx;
    logic hold_valid, par_bit, slot_end;
    logic accept, frame_start, load;

    assign tx_ready    = ~hold_valid;
    assign accept      = tx_valid && tx_ready;
    assign frame_start = (state == IDLE) || ((state == STOP) && slot_end && (bit_idx == LAST_STOP));
    assign load        = frame_start && (hold_valid || accept);
    // A held word always goes first; tx_data feeds the shifter directly only when the hold is empty.
    assign word_in     = hold_valid ? hold_reg : tx_data;

    os_tick_gen #(.OSR(OSR)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == IDLE),
        .en       (state != IDLE),
        .slot_end (slot_end)
    );

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = load ? START : IDLE;
        end else if (slot_end) begin
            case (state)
                START: state_nxt = DATA;
                DATA:  if (bit_idx == LAST_DATA) state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
                PAR:   state_nxt = STOP;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            tx_out     <= 1'b1;
            bit_idx    <= '0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (load) begin
                shift_reg  <= word_in;
                par_bit    <= parity_bit(9'(word_in), DATA_BITS, PARITY);
                bit_idx    <= '0;
                tx_out     <= 1'b0;
                hold_valid <= 1'b0;
            end else begin
                if (accept) begin
                    hold_reg   <= tx_data;
                    hold_valid <= 1'b1;
                end
                // The line level is registered, so each slot's level is chosen on the edge that opens it.
                if (frame_start) begin
                    tx_out <= 1'b1;
                end else if (slot_end) begin
                    case (state)
                        START: begin
                            tx_out  <= shift_reg[0];
                            bit_idx <= '0;
                        end
                        DATA: begin
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= '0;
                                tx_out  <= (PARITY != PAR_NONE) ? par_bit : 1'b1;
                            end else begin
                                bit_idx   <= bit_idx + 1'b1;
                                shift_reg <= shift_reg >> 1;
                                tx_out    <= shift_reg[1];
                            end
                        end
                        PAR: begin
                            tx_out  <= 1'b1;
                            bit_idx <= '0;
                        end
                        STOP: bit_idx <= bit_idx + 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_os.sv
// Bench for uart_tx_os: four configurations checked cycle by cycle against a frame-level line model.
module tb_uart_tx_os;

    localparam int OSR = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tx_valid = 4'b0;
    logic [7:0] tx_data [4];
    wire  [3:0] tx_ready, tx_out, busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int cfg_db  [4] = '{8, 8, 8, 7};
    int cfg_par [4] = '{0, 2, 1, 0};
    int cfg_sb  [4] = '{1, 1, 1, 2};

    bit         exp_line [4][512];
    int         exp_len  [4];
    int         exp_pos  [4];
    bit         held     [4];
    logic [7:0] hold_word[4];

    logic cap_out [4][640];
    logic cap_busy[4][640];
    logic cap_rdy [4][640];

    always #5 clk = ~clk;

    uart_tx_os #(.OSR(OSR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]));
    uart_tx_os #(.OSR(OSR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8e1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]));
    uart_tx_os #(.OSR(OSR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_8o1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]));
    uart_tx_os #(.OSR(OSR), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut_7n2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .tx_out(tx_out[3]), .busy(busy[3]));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expands one word into its per-cycle line levels: start, data LSB first, optional parity, stops.
    task automatic build_frame(input int k, input logic [7:0] w);
        int n, ones;
        bit pb;
        n = 0;
        ones = 0;
        for (int c = 0; c < OSR; c++) exp_line[k][n++] = 1'b0;
        for (int i = 0; i < cfg_db[k]; i++) begin
            ones += int'(w[i]);
            for (int c = 0; c < OSR; c++) exp_line[k][n++] = w[i];
        end
        if (cfg_par[k] != 0) begin
            pb = (cfg_par[k] == 2) ? bit'(ones % 2) : bit'(1 - ones % 2);
            for (int c = 0; c < OSR; c++) exp_line[k][n++] = pb;
        end
        for (int c = 0; c < OSR * cfg_sb[k]; c++) exp_line[k][n++] = 1'b1;
        exp_len[k] = n;
        exp_pos[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_len[k]   = 0;
            exp_pos[k]   = 0;
            held[k]      = 1'b0;
            hold_word[k] = 8'h00;
        end
    endtask

    task automatic model_step(input int k);
        bit acc;
        acc = tx_valid[k] && !held[k];
        if (exp_pos[k] < exp_len[k]) exp_pos[k]++;
        if (exp_pos[k] >= exp_len[k]) begin
            if (held[k]) begin
                build_frame(k, hold_word[k]);
                held[k] = 1'b0;
            end else if (acc) begin
                build_frame(k, tx_data[k]);
            end
        end else if (acc) begin
            held[k]      = 1'b1;
            hold_word[k] = tx_data[k];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else for (int k = 0; k < 4; k++) model_step(k);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 4; k++) begin
                    checkOutput($sformatf("tx_out%0d@%0t", k, $time), tx_out[k],
                                (exp_pos[k] < exp_len[k]) ? exp_line[k][exp_pos[k]] : 1'b1);
                    checkOutput($sformatf("busy%0d@%0t", k, $time), busy[k], exp_pos[k] < exp_len[k]);
                    checkOutput($sformatf("tx_ready%0d@%0t", k, $time), tx_ready[k], !held[k]);
                end
            end
        end
    end

    task automatic applyStimulus(input int k, input logic [7:0] w, input bit keep);
        bit ok, r;
        ok = 1'b0;
        tx_data[k]  = w;
        tx_valid[k] = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            r = tx_ready[k];
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
        end
        checkOutput($sformatf("accept%0d_%0h", k, w), ok, 1);
        if (!keep) tx_valid[k] = 1'b0;
    endtask

    task automatic capture(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                cap_out[k][start + i]  = tx_out[k];
                cap_busy[k][start + i] = busy[k];
                cap_rdy[k][start + i]  = tx_ready[k];
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int count_high(input int k, input int which, input int a, input int b);
        int n;
        n = 0;
        for (int c = a; c <= b; c++) begin
            if (which == 0 && cap_out[k][c] === 1'b1) n++;
            if (which == 1 && cap_busy[k][c] === 1'b1) n++;
            if (which == 2 && cap_rdy[k][c] === 1'b1) n++;
        end
        return n;
    endfunction

    initial begin
        int a5_exp [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int x81_exp[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        int acc_c;

        for (int k = 0; k < 4; k++) tx_data[k] = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("reset_tx_out%0d", k), tx_out[k], 1);
            checkOutput($sformatf("reset_busy%0d", k), busy[k], 0);
            checkOutput($sformatf("reset_tx_ready%0d", k), tx_ready[k], 1);
        end
        chk_en = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 8N1 single frame of 0xA5
        applyStimulus(0, 8'hA5, 1'b0);
        capture(0, 210);
        checkOutput("a5_busy_cycles", count_high(0, 1, 0, 209), 200);
        checkOutput("a5_busy_last", cap_busy[0][199], 1);
        checkOutput("a5_busy_after", cap_busy[0][200], 0);
        checkOutput("a5_ready_always", count_high(0, 2, 0, 209), 210);
        for (int s = 0; s < 10; s++)
            checkOutput($sformatf("a5_slot%0d", s), cap_out[0][s * OSR + 10], a5_exp[s]);

        // back-to-back 0x00 then 0xFF with valid held
        applyStimulus(0, 8'h00, 1'b1);
        tx_data[0] = 8'hFF;
        capture(0, 1);
        tx_valid[0] = 1'b0;
        capture(1, 419);
        checkOutput("b2b_busy_cycles", count_high(0, 1, 0, 419), 400);
        checkOutput("b2b_busy_399", cap_busy[0][399], 1);
        checkOutput("b2b_busy_400", cap_busy[0][400], 0);
        checkOutput("b2b_ready_1", cap_rdy[0][1], 0);
        checkOutput("b2b_ready_199", cap_rdy[0][199], 0);
        checkOutput("b2b_ready_200", cap_rdy[0][200], 1);
        checkOutput("b2b_stop1", cap_out[0][199], 1);
        checkOutput("b2b_start2", cap_out[0][200], 0);
        checkOutput("b2b_high_cycles", count_high(0, 0, 0, 399), 200);

        // 0x07 with even and odd parity side by side
        tx_data[1] = 8'h07;
        tx_data[2] = 8'h07;
        tx_valid[2:1] = 2'b11;
        @(posedge clk);
        #1;
        tx_valid[2:1] = 2'b00;
        capture(0, 230);
        checkOutput("even_par_slot", cap_out[1][190], 1);
        checkOutput("odd_par_slot", cap_out[2][190], 0);
        checkOutput("even_busy_cycles", count_high(1, 1, 0, 229), 220);
        checkOutput("odd_busy_cycles", count_high(2, 1, 0, 229), 220);
        checkOutput("even_stop", cap_out[1][210], 1);

        // backpressure: 0x3C waits with valid high while the hold register is full
        applyStimulus(0, 8'h12, 1'b1);
        tx_data[0] = 8'h34;
        capture(0, 1);
        tx_data[0] = 8'h3C;
        acc_c = -1;
        for (int c = 1; c < 620; c++) begin
            capture(c, 1);
            if (tx_valid[0] && cap_rdy[0][c] === 1'b1) begin
                tx_valid[0] = 1'b0;
                acc_c = c;
            end
        end
        tx_valid[0] = 1'b0;
        checkOutput("bp_no_ready_while_full", count_high(0, 2, 1, 199), 0);
        checkOutput("bp_accept_cycle", acc_c, 200);
        checkOutput("bp_ready_201", cap_rdy[0][201], 0);
        checkOutput("bp_busy_cycles", count_high(0, 1, 0, 619), 600);
        checkOutput("bp_frame3_start", cap_out[0][400], 0);

        // reset during data bit 3 of 0x55 with 0x99 held
        applyStimulus(0, 8'h55, 1'b0);
        tx_data[0]  = 8'h99;
        tx_valid[0] = 1'b1;
        capture(0, 1);
        tx_valid[0] = 1'b0;
        capture(1, 84);
        checkOutput("rst_hold_full", tx_ready[0], 0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_tx_out", tx_out[0], 1);
        checkOutput("rst_async_busy", busy[0], 0);
        checkOutput("rst_async_ready", tx_ready[0], 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        capture(0, 30);
        checkOutput("rst_hold_gone", count_high(0, 1, 0, 29), 0);
        applyStimulus(0, 8'h81, 1'b0);
        capture(0, 210);
        checkOutput("x81_busy_cycles", count_high(0, 1, 0, 209), 200);
        for (int s = 0; s < 10; s++)
            checkOutput($sformatf("x81_slot%0d", s), cap_out[0][s * OSR + 10], x81_exp[s]);

        // 7N2 frame of 0x7F
        applyStimulus(3, 8'h7F, 1'b0);
        capture(0, 210);
        checkOutput("7n2_busy_cycles", count_high(3, 1, 0, 209), 200);
        checkOutput("7n2_start", cap_out[3][10], 0);
        checkOutput("7n2_data_high", count_high(3, 0, 20, 159), 140);
        checkOutput("7n2_stop_high", count_high(3, 0, 160, 199), 40);
        checkOutput("7n2_busy_after", cap_busy[3][200], 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
